// File: rtl/router_pkg.sv
// Shared types and default widths for the router input ports and switching core.
package router_pkg;

  localparam int ROUTER_ADDR_W = 4;
  localparam int ROUTER_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    PAD   = 3'd2,
    DATA  = 3'd3,
    DRAIN = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic [ROUTER_ADDR_W-1:0] da;
    logic [ROUTER_DATA_W-1:0] data;
  } rx_pkt_t;

endpackage

// File: rtl/router_port_rx.sv
// Router input port receiver: deserialises frame_n/valid_n/di packets
// (address, padding, payload, all LSB first) into a parallel word held on a
// valid/ready output register. Malformed frames and drops on a full output
// register are flagged with one-cycle error pulses.
module router_port_rx
  import router_pkg::*;
#(
  parameter int ADDR_W = ROUTER_ADDR_W,
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_n,
  input  logic              valid_n,
  input  logic              di,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [ADDR_W-1:0] pkt_da,
  output logic [DATA_W-1:0] pkt_data,
  output logic              frm_err,
  output logic              ovf_err,
  output logic [7:0]        pkt_cnt
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_W - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_cap_s;
  logic [DATA_W-1:0] data_q, data_d, data_cap_s;
  logic              complete_s, frm_err_s, load_s, ovf_s;

  logic              pkt_valid_q, pkt_valid_d;
  logic [ADDR_W-1:0] pkt_da_q, pkt_da_d;
  logic [DATA_W-1:0] pkt_data_q, pkt_data_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d;
  logic              frm_err_q, ovf_err_q;

  // Shift-register images with the current di written at the bit index.
  always_comb begin
    addr_cap_s = addr_q;
    data_cap_s = data_q;
    for (int i = 0; i < ADDR_W; i++) begin
      if (idx_q == IDX_W'(i)) addr_cap_s[i] = di;
      else                    addr_cap_s[i] = addr_q[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (idx_q == IDX_W'(i)) data_cap_s[i] = di;
      else                    data_cap_s[i] = data_q[i];
    end
  end

  // Frame parser: next state, bit index, captures, completion and frame errors.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    complete_s = 1'b0;
    frm_err_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!frame_n) begin
          addr_d = addr_cap_s;
          if (ADDR_W == 1) begin
            state_d = PAD;
            idx_d   = '0;
          end else begin
            state_d = ADDR;
            idx_d   = IDX_W'(1);
          end
        end else begin
          idx_d = '0;
        end
      end
      ADDR: begin
        if (frame_n) begin
          frm_err_s = 1'b1;
          state_d   = IDLE;
          idx_d     = '0;
        end else if (!valid_n) begin
          frm_err_s = 1'b1;
          state_d   = DRAIN;
          idx_d     = '0;
        end else begin
          addr_d = addr_cap_s;
          if (idx_q == ADDR_LAST) begin
            state_d = PAD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          frm_err_s = 1'b1;
          state_d   = IDLE;
          idx_d     = '0;
        end else if (!valid_n) begin
          data_d  = data_cap_s;
          state_d = DATA;
          idx_d   = IDX_W'(1);
        end else begin
          state_d = PAD;
        end
      end
      DATA: begin
        if (!valid_n) begin
          data_d = data_cap_s;
          if (frame_n) begin
            // Frame end: complete only if this was the last payload bit.
            if (idx_q == DATA_LAST) complete_s = 1'b1;
            else                    frm_err_s  = 1'b1;
            state_d = IDLE;
            idx_d   = '0;
          end else if (idx_q == DATA_LAST) begin
            frm_err_s = 1'b1;
            state_d   = DRAIN;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (frame_n) begin
          frm_err_s = 1'b1;
          state_d   = IDLE;
          idx_d     = '0;
        end else begin
          state_d = DATA;
        end
      end
      DRAIN: begin
        if (frame_n) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign load_s = complete_s & (~pkt_valid_q | pkt_ready);
  assign ovf_s  = complete_s & pkt_valid_q & ~pkt_ready;

  // Output register: load on completion, clear on acceptance, otherwise hold.
  always_comb begin
    pkt_valid_d = pkt_valid_q;
    pkt_da_d    = pkt_da_q;
    pkt_data_d  = pkt_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    if (load_s) begin
      pkt_valid_d = 1'b1;
      pkt_da_d    = addr_q;
      pkt_data_d  = data_cap_s;
      pkt_cnt_d   = pkt_cnt_q + 8'd1;
    end else if (pkt_valid_q && pkt_ready) begin
      pkt_valid_d = 1'b0;
    end else begin
      pkt_valid_d = pkt_valid_q;
    end
  end

  // State, shift registers, output register and error pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pkt_valid_q <= 1'b0;
      pkt_da_q    <= '0;
      pkt_data_q  <= '0;
      pkt_cnt_q   <= 8'd0;
      frm_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_da_q    <= pkt_da_d;
      pkt_data_q  <= pkt_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      frm_err_q   <= frm_err_s;
      ovf_err_q   <= ovf_s;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign pkt_da    = pkt_da_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign frm_err   = frm_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: doc/router_port_rx.md
# router_port_rx

Serial-to-parallel receiver for one router input port. It parses the bit-serial packet protocol that port sources drive: `frame_n`, `valid_n` and `di`, carrying a 4-bit destination address, padding, then a 32-bit payload, all LSB first. It presents each complete packet as a parallel word on a valid/ready interface for the router's switching core. One instance per input port; the router instantiates eight.

## Interface
- `ADDR_W`, default 4: destination address bits, sent LSB first.
- `DATA_W`, default 32: payload bits, sent LSB first.
- `clock` in 1: sole clock; all activity on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `frame_n` in 1: active-low frame. Low for the whole packet; goes high together with the last payload bit.
- `valid_n` in 1: active-low payload-bit qualifier.
- `di` in 1: serial data.
- `pkt_valid` out 1: parallel packet available.
- `pkt_ready` in 1: consumer accepts the packet when `pkt_valid & pkt_ready`.
- `pkt_da` out ADDR_W: destination address.
- `pkt_data` out DATA_W: payload.
- `frm_err` out 1: one-cycle pulse on a malformed frame.
- `ovf_err` out 1: one-cycle pulse when a good packet is dropped because the output register is full.
- `pkt_cnt` out 8: packets delivered into the output register; wraps 255→0.

## Operation
- **States:** IDLE, ADDR, PAD, DATA, DRAIN.
- **IDLE:** on `frame_n=0`, capture `di` as address bit 0; go to ADDR with bit index 1.
  - `ADDR_W=1` goes straight to PAD.
  - `valid_n=0` with `frame_n=1` is ignored.
- **ADDR:** capture `di` into address bit[index] each cycle; after bit ADDR_W-1, go to PAD.
  - `frame_n=1` → `frm_err`, go to IDLE.
  - `valid_n=0` → `frm_err`, go to DRAIN.
- **PAD:** `di` is ignored while `valid_n=1`; padding length is unbounded.
  - `valid_n=0` → capture payload bit 0, go to DATA with index 1.
  - `frame_n=1` → `frm_err`, go to IDLE.
- **DATA:** each cycle with `valid_n=0`, capture `di` into payload bit[index]. A cycle with `valid_n=1` is a stall: no capture, no error.
  - A valid bit with `frame_n=1`: if index = DATA_W-1, the packet is complete; go to IDLE. Otherwise (short frame) → `frm_err`, go to IDLE.
  - Valid bit DATA_W-1 with `frame_n=0` (long frame) → `frm_err`, go to DRAIN.
  - `frame_n=1` with `valid_n=1` → `frm_err`, go to IDLE.
- **DRAIN:** wait for `frame_n=1`, then go to IDLE. No capture.
- **Completion:** the output register is loaded if it is empty or is being accepted in the same cycle.
  - On load, `pkt_cnt` increments.
  - If the register is full and not being accepted, the packet is discarded, `ovf_err` pulses, and the held packet is unchanged.
- **Output hold:** `pkt_da`/`pkt_data` hold stable while `pkt_valid=1` and not accepted. They update only on load.

## Timing
- **Reset:** all outputs 0 (`pkt_valid`, `pkt_da`, `pkt_data`, `frm_err`, `ovf_err`, `pkt_cnt`); state = IDLE.
  - Reset asserted mid-packet discards the partial packet and any held output.
  - After reset, the first `frame_n=0` sample starts a new frame.
- **Latency:** the same rising edge that samples the final payload bit sets `pkt_valid`. Data is visible in the following cycle.
  - With a 10-cycle pad and no stalls, `pkt_valid` rises at the 46th sampling edge after the frame start (edges 0..45).
- **Handshake:** on the edge where `pkt_valid & pkt_ready`, `pkt_valid` clears, unless a completion on the same edge reloads it (stays 1, new data).
- **Error pulses:** `frm_err` and `ovf_err` are registered, high for exactly one cycle, asserted on the edge that detects the condition.
- **Back-to-back frames:** `frame_n=0` on the cycle right after a completed frame starts a new frame with no bubble.
- **Upstream backpressure:** none. The serial side never stalls on `pkt_ready`.

## Structure
- Shared package `router_pkg`:
  - `ADDR_W`/`DATA_W` defaults as localparams.
  - State enum `rx_state_e` {IDLE, ADDR, PAD, DATA, DRAIN}.
  - Packed struct `rx_pkt_t` {da, data}, reused by the switching core.
- Single module. There is no natural sub-module; the shift registers and index counter stay inline.
- Index counter width: $clog2(DATA_W). It resets to 0 on every IDLE entry.

## Test plan
- **Single packet:** da=7, data=32'hdead_beef, 10 pad, `pkt_ready=1` → one `pkt_valid` pulse at sampling edge 45; `pkt_da=7`, `pkt_data=deadbeef`; `pkt_cnt=1`.
- **Sequential packets:** 10 back-to-back packets da=0..7,0,1 with random payloads and 1 idle cycle between them → 10 deliveries in order, exact payload match, `pkt_cnt=10`, no error pulses.
- **Overflow:** `pkt_ready=0`, send packets A then B → A is held unchanged, `ovf_err` pulses once at B's last bit; raise `pkt_ready` → A delivered; `pkt_cnt=1`.
- **Short frame:** `frame_n` rises with payload bit 15 → `frm_err` pulse, no `pkt_valid`. The next well-formed packet is received correctly.
- **Long frame and ADDR error:** 33 valid bits → `frm_err` at bit 31, DRAIN until `frame_n=1`. `valid_n=0` during the address phase → `frm_err`.
- **Reset mid-DATA plus stall:** reset at payload bit 20 → outputs 0, the partial frame is lost. A packet with `valid_n` high for 3 cycles mid-payload still delivers its payload intact, 3 cycles later than unstalled.
